// File: rtl/qdriip_traffic_gen.sv
// rtl/qdriip_traffic_gen.sv - QDRII+ user-port traffic generator: writes a seeded pattern, reads it back, checks it.
module qdriip_traffic_gen #(
    parameter int          NUM_WRITES   = 10,
    parameter int          ADDR_WIDTH   = 22,
    parameter int          DATA_WIDTH   = 72,
    parameter int          START_ADDR   = 0,
    parameter logic [15:0] PATTERN_SEED = 16'hA5C3,
    parameter int          WR_TO_RD_GAP = 32,
    parameter int          RD_TIMEOUT   = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  init_calib_complete,
    output logic                  app_wr_cmd0,
    output logic [ADDR_WIDTH-1:0] app_wr_addr0,
    output logic [DATA_WIDTH-1:0] app_wr_data0,
    output logic [7:0]            app_wr_bw_n0,
    output logic                  app_rd_cmd0,
    output logic [ADDR_WIDTH-1:0] app_rd_addr0,
    input  logic                  app_rd_valid0,
    input  logic [DATA_WIDTH-1:0] app_rd_data0,
    output logic                  done,
    output logic                  pass,
    output logic                  timeout,
    output logic [15:0]           err_count,
    output logic [15:0]           first_err_idx
);

    typedef enum logic [2:0] {
        S_IDLE, S_WRITE, S_GAP, S_READ, S_WAIT_DATA, S_DONE
    } state_t;

    localparam logic [15:0]           NUM_BURSTS = 16'(NUM_WRITES);
    localparam logic [15:0]           LAST_IDX   = 16'(NUM_WRITES - 1);
    localparam logic [7:0]            GAP_LAST   = 8'(WR_TO_RD_GAP - 1);
    localparam logic [15:0]           TMO_LAST   = 16'(RD_TIMEOUT - 1);
    localparam logic [ADDR_WIDTH-1:0] BASE_ADDR  = ADDR_WIDTH'(START_ADDR);
    localparam logic [15:0]           NO_ERR_IDX = 16'hFFFF;

    function automatic logic [DATA_WIDTH-1:0] pattern(input logic [15:0] idx);
        logic [DATA_WIDTH-1:0] p;
        p = '0;
        for (int b = 0; b < DATA_WIDTH / 18; b++) begin
            p[18*b +: 18] = {2'(b), idx ^ PATTERN_SEED};
        end
        return p;
    endfunction

    state_t                state_q, state_d;
    logic [15:0]           cmd_idx_q, cmd_idx_d;
    logic [7:0]            gap_cnt_q, gap_cnt_d;
    logic [15:0]           tmo_cnt_q, tmo_cnt_d;
    logic [15:0]           rcv_cnt_q, rcv_cnt_d;
    logic                  wr_cmd_q, wr_cmd_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic [7:0]            bw_n_q, bw_n_d;
    logic                  rd_cmd_q, rd_cmd_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic                  done_q, done_d;
    logic                  pass_q, pass_d;
    logic                  timeout_q, timeout_d;
    logic [15:0]           err_cnt_q, err_cnt_d;
    logic [15:0]           first_err_q, first_err_d;
    logic                  err_bump;

    always_comb begin
        state_d     = state_q;
        cmd_idx_d   = cmd_idx_q;
        gap_cnt_d   = gap_cnt_q;
        tmo_cnt_d   = tmo_cnt_q;
        rcv_cnt_d   = rcv_cnt_q;
        wr_cmd_d    = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        bw_n_d      = bw_n_q;
        rd_cmd_d    = 1'b0;
        rd_addr_d   = rd_addr_q;
        done_d      = done_q;
        pass_d      = pass_q;
        timeout_d   = timeout_q;
        err_cnt_d   = err_cnt_q;
        first_err_d = first_err_q;
        err_bump    = 1'b0;

        // cmd_idx_q doubles as the issued-read count while reading or waiting
        if ((state_q == S_READ || state_q == S_WAIT_DATA) && app_rd_valid0) begin
            if (rcv_cnt_q < cmd_idx_q) begin
                if (app_rd_data0 != pattern(rcv_cnt_q)) begin
                    err_bump = 1'b1;
                    if (first_err_q == NO_ERR_IDX) begin
                        first_err_d = rcv_cnt_q;
                    end
                end
                rcv_cnt_d = rcv_cnt_q + 16'd1;
            end else begin
                err_bump = 1'b1;
            end
        end
        if (err_bump && err_cnt_q != 16'hFFFF) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end

        case (state_q)
            S_IDLE: begin
                if (init_calib_complete) begin
                    state_d   = S_WRITE;
                    cmd_idx_d = '0;
                end
            end
            S_WRITE: begin
                wr_cmd_d  = 1'b1;
                wr_addr_d = BASE_ADDR + ADDR_WIDTH'(cmd_idx_q);
                wr_data_d = pattern(cmd_idx_q);
                bw_n_d    = 8'h00;
                if (cmd_idx_q == LAST_IDX) begin
                    state_d   = S_GAP;
                    cmd_idx_d = '0;
                    gap_cnt_d = '0;
                end else begin
                    cmd_idx_d = cmd_idx_q + 16'd1;
                end
            end
            S_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d   = S_READ;
                    rcv_cnt_d = '0;
                end else begin
                    gap_cnt_d = gap_cnt_q + 8'd1;
                end
            end
            S_READ: begin
                rd_cmd_d  = 1'b1;
                rd_addr_d = BASE_ADDR + ADDR_WIDTH'(cmd_idx_q);
                cmd_idx_d = cmd_idx_q + 16'd1;
                if (cmd_idx_q == LAST_IDX) begin
                    state_d   = S_WAIT_DATA;
                    tmo_cnt_d = '0;
                end
            end
            S_WAIT_DATA: begin
                // err_cnt_d so a stray arriving on the final cycle is reflected in pass
                if (rcv_cnt_q == NUM_BURSTS || timeout_q) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    pass_d  = (err_cnt_d == 16'd0) && !timeout_q;
                end else if (app_rd_valid0) begin
                    tmo_cnt_d = '0;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 16'd1;
                    if (tmo_cnt_q == TMO_LAST) begin
                        timeout_d = 1'b1;
                    end
                end
            end
            S_DONE: begin
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cmd_idx_q   <= '0;
            gap_cnt_q   <= '0;
            tmo_cnt_q   <= '0;
            rcv_cnt_q   <= '0;
            wr_cmd_q    <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            bw_n_q      <= 8'hFF;
            rd_cmd_q    <= 1'b0;
            rd_addr_q   <= '0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            timeout_q   <= 1'b0;
            err_cnt_q   <= '0;
            first_err_q <= NO_ERR_IDX;
        end else begin
            state_q     <= state_d;
            cmd_idx_q   <= cmd_idx_d;
            gap_cnt_q   <= gap_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
            rcv_cnt_q   <= rcv_cnt_d;
            wr_cmd_q    <= wr_cmd_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            bw_n_q      <= bw_n_d;
            rd_cmd_q    <= rd_cmd_d;
            rd_addr_q   <= rd_addr_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            timeout_q   <= timeout_d;
            err_cnt_q   <= err_cnt_d;
            first_err_q <= first_err_d;
        end
    end

    assign app_wr_cmd0   = wr_cmd_q;
    assign app_wr_addr0  = wr_addr_q;
    assign app_wr_data0  = wr_data_q;
    assign app_wr_bw_n0  = bw_n_q;
    assign app_rd_cmd0   = rd_cmd_q;
    assign app_rd_addr0  = rd_addr_q;
    assign done          = done_q;
    assign pass          = pass_q;
    assign timeout       = timeout_q;
    assign err_count     = err_cnt_q;
    assign first_err_idx = first_err_q;

endmodule

// File: doc/qdriip_traffic_gen.md
# qdriip_traffic_gen

Self-checking traffic generator for the simple QDRII+ reference design. It sits between the MIG QDRII+ user interface (port 0) and the top-level `done` indication. After calibration it writes NUM_WRITES bursts of a deterministic pattern and reads them back. It compares every returned burst and reports `done`, pass/fail, a timeout flag and error statistics; the simulation bench waits on `done`.

## Interface
Parameters:
- NUM_WRITES, 10: bursts written then read; legal 1..65535.
- ADDR_WIDTH, 22: user address width.
- DATA_WIDTH, 72: burst width, 4 beats × 18 bits; beat b occupies bits [18b+17:18b].
- START_ADDR, 0: address of burst 0; burst i uses START_ADDR+i, modulo 2^ADDR_WIDTH.
- PATTERN_SEED, 16'hA5C3: XOR seed for data pattern.
- WR_TO_RD_GAP, 32: idle cycles between last write and first read; legal 1..255.
- RD_TIMEOUT, 1024: cycles without read data before abort; legal 1..65535.

Ports:
- clk  in  1  MIG user clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- init_calib_complete  in  1  MIG calibration done.
- app_wr_cmd0  out  1  write command strobe, one burst per cycle.
- app_wr_addr0  out  ADDR_WIDTH  write address.
- app_wr_data0  out  DATA_WIDTH  write data.
- app_wr_bw_n0  out  8  byte-write enables, active low.
- app_rd_cmd0  out  1  read command strobe.
- app_rd_addr0  out  ADDR_WIDTH  read address.
- app_rd_valid0  in  1  read data valid, in-order returns.
- app_rd_data0  in  DATA_WIDTH  read data.
- done  out  1  test finished; sticky until rst.
- pass  out  1  valid when done: all bursts matched, no timeout.
- timeout  out  1  read data stalled for RD_TIMEOUT cycles; sticky.
- err_count  out  16  mismatched or stray bursts, saturating at 16'hFFFF.
- first_err_idx  out  16  burst index of first mismatch; 16'hFFFF if none.

## Operation
- Pattern for burst i, beat b: {b[1:0], i[15:0] ^ PATTERN_SEED}. Writes always drive `app_wr_bw_n0 = 8'h00`.
- The MIG UI has no backpressure, so one command is issued per cycle while in WRITE or READ.
- FSM states: IDLE → WRITE → GAP → READ → WAIT_DATA → DONE.
  - IDLE: leave on the first cycle `init_calib_complete` is 1. Deassertion of `init_calib_complete` after IDLE is ignored.
  - WRITE: issue bursts i = 0..NUM_WRITES-1 on consecutive cycles, then go to GAP.
  - GAP: count WR_TO_RD_GAP cycles, then go to READ.
  - READ: issue reads i = 0..NUM_WRITES-1 on consecutive cycles, then go to WAIT_DATA.
  - WAIT_DATA: go to DONE when received == NUM_WRITES, or when the timeout counter reaches RD_TIMEOUT.
  - DONE: terminal state; only rst leaves it.
- Receive path operates in READ and WAIT_DATA:
  - Each `app_rd_valid0` with received < issued compares `app_rd_data0` against pattern(received), then increments received.
  - A mismatch increments err_count and, if this is the first error, latches first_err_idx = received.
  - `app_rd_valid0` with received == issued is a stray: err_count increments and first_err_idx is unchanged.
  - In all other states `app_rd_valid0` is ignored.
- Timeout counter:
  - Cleared on every `app_rd_valid0` and on entry to WAIT_DATA; increments each WAIT_DATA cycle otherwise.
  - Reaching RD_TIMEOUT sets `timeout`.
- `pass` = (err_count == 0) && !timeout, registered on entry to DONE.

## Timing
- Reset values: all command strobes 0, addresses/data 0, bw_n 8'hFF, done 0, pass 0, timeout 0, err_count 0, first_err_idx 16'hFFFF. FSM returns to IDLE; counters clear.
- rst asserted mid-operation aborts on the next edge; in-flight read data after reset is ignored until READ.
- All outputs are registered.
- First `app_wr_cmd0` appears 1 cycle after the first clk edge sampling `init_calib_complete` = 1.
- Write phase lasts exactly NUM_WRITES cycles.
- First `app_rd_cmd0` comes WR_TO_RD_GAP+1 cycles after the last `app_wr_cmd0`.
- `done` rises 1 cycle after the final compare or the timeout condition; `pass`, `err_count` and `first_err_idx` are stable in that same cycle.
- A simultaneous mismatch and timeout cannot occur, because valid clears the counter.
- Burst address wraps modulo 2^ADDR_WIDTH.

## Test plan
- Loopback model (rd data = stored wr data, latency 20), NUM_WRITES=10 → 10 wr cmds at addresses 0..9, 10 rd cmds, done=1, pass=1, err_count=0, first_err_idx=16'hFFFF.
- Corrupt bit 0 of burst 3 read data → done=1, pass=0, err_count=1, first_err_idx=3.
- Model never returns read data, RD_TIMEOUT=100 → done exactly 101 cycles after entering WAIT_DATA, timeout=1, pass=0.
- `init_calib_complete` held 0 for 500 cycles → no commands issued and done=0; raise it → first wr cmd 1 cycle later.
- Assert rst for 1 cycle during READ at burst 5 → all outputs return to reset values; the rerun completes with pass=1.
- START_ADDR=2^22-2, NUM_WRITES=4 → write addresses 3FFFFE, 3FFFFF, 0, 1; extra rd_valid after the 4th return → err_count=1.
